transfer_address_unit: RTL

//  Consumer end of the transfer register: samples TR1 at each instruction boundary and either

---
 rtl/transfer_address_unit_pkg.sv | 17 +
 rtl/transfer_address_unit_ic_serializer.sv | 62 ++++++
 rtl/transfer_address_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/transfer_address_unit_pkg.sv
// Shared types and constants for the transfer address unit and its IC serializer.
package transfer_address_unit_pkg;

    localparam int unsigned DefaultAw = 8;

    typedef enum logic [1:0] {
        StIdle,
        StUpdate,
        StShift
    } tau_state_e;

    // Bit counter must hold AW+1 (address bits plus syllable bit).
    function automatic int unsigned cnt_width(input int unsigned aw);
        return $clog2(aw + 2);
    endfunction

endpackage

// File: rtl/transfer_address_unit_ic_serializer.sv
// Parallel-load shifter that sends {syllable, address} LSB first, one bit per cycle.
module transfer_address_unit_ic_serializer
    import transfer_address_unit_pkg::*;
#(
    parameter int unsigned AW = DefaultAw
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        load_i,
    input  logic [AW:0] data_i,
    output logic        ser_out_o,
    output logic        ser_vld_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned CntW = cnt_width(AW);

    logic [AW:0]     sh_q;
    logic [CntW-1:0] cnt_q;
    logic            ser_out_q;
    logic            vld_q;
    logic            busy_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q      <= '0;
            cnt_q     <= '0;
            ser_out_q <= 1'b0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (start_i) begin
                busy_q <= 1'b1;
            end
            if (load_i) begin
                // Bit 0 goes out immediately; cnt_q counts the bits still to come.
                ser_out_q <= data_i[0];
                sh_q      <= data_i >> 1;
                cnt_q     <= CntW'(AW);
                vld_q     <= 1'b1;
            end else if (vld_q) begin
                if (cnt_q == '0) begin
                    ser_out_q <= 1'b0;
                    vld_q     <= 1'b0;
                    busy_q    <= 1'b0;
                end else begin
                    ser_out_q <= sh_q[0];
                    sh_q      <= sh_q >> 1;
                    cnt_q     <= cnt_q - CntW'(1);
                end
            end
        end
    end

    assign ser_out_o = ser_out_q;
    assign ser_vld_o = vld_q;
    assign busy_o    = busy_q;
    assign done_o    = vld_q && (cnt_q == '0);

endmodule

// File: rtl/transfer_address_unit.sv
// Instruction counter update on instruction boundaries, transfer-register clear pulse and
// serial IC output. Optional return-point capture (SAVED_IC) enabled by macro HOP_SAVE_EN.
module transfer_address_unit
    import transfer_address_unit_pkg::*;
#(
    parameter int unsigned AW     = DefaultAw,
    parameter bit          SYL_EN = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tr1_i,
    input  logic          instr_end_i,
    input  logic [AW-1:0] tgt_addr_i,
    input  logic          tgt_syl_i,
    output logic          cltr_o,
    output logic [AW:0]   ic_o,
`ifdef HOP_SAVE_EN
    output logic [AW:0]   saved_ic_o,
`endif
    output logic          ser_out_o,
    output logic          ser_vld_o,
    output logic          busy_o,
    output logic          seq_err_o
);

    tau_state_e  state_q;
    logic [AW:0] ic_q, ic_d;
    logic        cltr_q;
    logic        seq_err_q;
    logic        accept;
    logic        take;
    logic        ser_done;

    assign accept = (state_q == StIdle) && instr_end_i;
    assign take   = accept && tr1_i;

    always_comb begin
        ic_d = ic_q;
        if (take) begin
            ic_d = {(SYL_EN ? tgt_syl_i : 1'b0), tgt_addr_i};
        end else if (accept) begin
            // Sequential step wraps silently inside the address field.
            ic_d = {ic_q[AW], ic_q[AW-1:0] + AW'(1)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ic_q      <= '0;
            cltr_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            ic_q   <= ic_d;
            cltr_q <= take;
            if (instr_end_i && (state_q != StIdle)) begin
                seq_err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle:   if (instr_end_i) state_q <= StUpdate;
                StUpdate: state_q <= StShift;
                StShift:  if (ser_done) state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

`ifdef HOP_SAVE_EN
    logic [AW:0] saved_ic_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            saved_ic_q <= '0;
        end else if (take) begin
            saved_ic_q <= ic_q;
        end
    end

    assign saved_ic_o = saved_ic_q;
`endif

    transfer_address_unit_ic_serializer #(
        .AW(AW)
    ) u_ser (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (accept),
        .load_i    (state_q == StUpdate),
        .data_i    (ic_q),
        .ser_out_o (ser_out_o),
        .ser_vld_o (ser_vld_o),
        .busy_o    (busy_o),
        .done_o    (ser_done)
    );

    assign cltr_o    = cltr_q;
    assign ic_o      = ic_q;
    assign seq_err_o = seq_err_q;

endmodule
